// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// counter sizing helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W_DEFAULT = $clog2(16 + 1);

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder, the only arithmetic in the serial datapath.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ ci;
    assign c = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock.
// Optional zf/nf flag outputs are enabled by defining ADDSUB_FLAGS_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] result_next;

    serial_fa_cell u_fa (
        .x  (a_reg[0]),
        .y  (b_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .c  (fa_c)
    );

    assign result_next = {fa_s, result[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
`ifdef ADDSUB_FLAGS_EN
            zf        <= 1'b0;
            nf        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        result    <= '0;
                        state_reg <= ST_RUN;
                        busy      <= 1'b1;
                        ready     <= 1'b0;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    result    <= result_next;
                    a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
                    carry_reg <= fa_c;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        // carry_reg here is the carry into the MSB
                        cout      <= fa_c;
                        ovf       <= carry_reg ^ fa_c;
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
`ifdef ADDSUB_FLAGS_EN
                        zf        <= (result_next == '0);
                        nf        <= fa_s;
`endif
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Random and directed bench for serial_addsub (WIDTH=16) against an
// arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;
`ifdef ADDSUB_FLAGS_EN
    logic          zf;
    logic          nf;
`endif

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
`ifdef ADDSUB_FLAGS_EN
        ,
        .zf     (zf),
        .nf     (nf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one op from IDLE or DONE; returns at the negedge where done is seen.
    // glitch>0 pulses start with a different operand after that many RUN edges.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic osub, input int glitch);
        int          sa, sb, sr;
        logic [W:0]  wide;
        logic [W-1:0] er;
        logic        ec, eo;
        int          n;
        sa = int'($signed(oa));
        sb = int'($signed(ob));
        sr = osub ? sa - sb : sa + sb;
        wide = osub ? ({1'b0, oa} - {1'b0, ob}) : ({1'b0, oa} + {1'b0, ob});
        er = wide[W-1:0];
        ec = osub ? (oa >= ob) : wide[W];
        eo = (sr > 32767) || (sr < -32768);

        start = 1'b1; a = oa; b = ob; sub = osub;
        @(posedge clk); @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_in_run", {31'd0, ready}, 32'd0);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        n = 1;
        while (!done && n < 40) begin
            if (glitch > 0 && n - 1 == glitch) begin
                start = 1'b1; a = 16'h1234; sub = ~osub;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency_edges", n, W + 1);
        check("result", {16'd0, result}, {16'd0, er});
        check("cout", {31'd0, cout}, {31'd0, ec});
        check("ovf", {31'd0, ovf}, {31'd0, eo});
`ifdef ADDSUB_FLAGS_EN
        check("zf", {31'd0, zf}, {31'd0, (er == 0)});
        check("nf", {31'd0, nf}, {31'd0, er[W-1]});
`endif
        $display("op a=%04h b=%04h sub=%0d -> result=%04h cout=%0d ovf=%0d edges=%0d",
                 oa, ob, osub, result, cout, ovf, n);
    endtask

    task automatic idle_cycle(input logic [W-1:0] held);
        @(posedge clk); @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_idle", {31'd0, ready}, 32'd1);
        check("result_held", {16'd0, result}, {16'd0, held});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(16'h0001, 16'h0001, 1'b0, 0); idle_cycle(16'h0002);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0); idle_cycle(16'h0000);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0); idle_cycle(16'h8000);
        do_op(16'h0005, 16'h0007, 1'b1, 0); idle_cycle(16'hFFFE);
        do_op(16'h8000, 16'h0001, 1'b1, 0); idle_cycle(16'h7FFF);

        // Start pulse during RUN must be ignored
        do_op(16'h1111, 16'h2222, 1'b0, 3); idle_cycle(16'h3333);

        // Back-to-back: start asserted while in DONE
        do_op(16'h00F0, 16'h000F, 1'b0, 0);
        do_op(16'h1234, 16'h1234, 1'b1, 0);
        idle_cycle(16'h0000);

        // Reset in the middle of an operation
        start = 1'b1; a = 16'hABCD; b = 16'h1111; sub = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_no_done", {31'd0, done}, 32'd0);
        do_op(16'h00FF, 16'h0F0F, 1'b0, 0); idle_cycle(16'h100E);

        for (int i = 0; i < 2000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) idle_cycle(result);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
